// File: rtl/lock_supervisor.sv
// Keypad lock sequencer: synchronises enter/digit, walks the code, tracks failures,
// enforces a timed lockout and supports reprogramming while unlocked.
module lock_supervisor #(
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_raw,
  input  logic [3:0] digit_raw,
  input  logic       prog_req,
  input  logic       relock,
  output logic       locked,
  output logic       unlocked,
  output logic       error,
  output logic       lockout,
  output logic [1:0] fail_count,
  output logic [1:0] digit_idx,
  output logic [2:0] state_code
);

  localparam int unsigned TW         = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [1:0]  LAST_IDX   = 2'(CODE_LEN - 1);
  localparam logic [1:0]  FAIL_MAX   = 2'(MAX_FAILS);
  localparam logic [TW-1:0] TIMER_INIT = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'b000,
    S_ENTRY    = 3'b001,
    S_ERROR    = 3'b010,
    S_UNLOCKED = 3'b011,
    S_LOCKOUT  = 3'b100,
    S_PROGRAM  = 3'b101
  } state_e;

  // Digit 0 lives in the top nibble.
  function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] r;
    case (i)
      2'd0:    r = v[15:12];
      2'd1:    r = v[11:8];
      2'd2:    r = v[7:4];
      default: r = v[3:0];
    endcase
    return r;
  endfunction

  function automatic logic [15:0] set_nib(input logic [15:0] v, input logic [1:0] i,
                                          input logic [3:0] d);
    logic [15:0] r;
    r = v;
    case (i)
      2'd0:    r[15:12] = d;
      2'd1:    r[11:8]  = d;
      2'd2:    r[7:4]   = d;
      default: r[3:0]   = d;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [15:0]   code_q, code_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [1:0]    digit_idx_q, digit_idx_d;
  logic [1:0]    fail_count_q, fail_count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          enter_s1_q, enter_s2_q, enter_prev_q;
  logic [3:0]    digit_s1_q, digit_s2_q;
  logic          locked_q, locked_d;
  logic          unlocked_q, unlocked_d;
  logic          error_q, error_d;
  logic          lockout_q, lockout_d;

  logic enter_pulse;
  logic digit_match;

  assign enter_pulse = enter_s2_q & ~enter_prev_q;
  assign digit_match = (digit_s2_q == nib(code_q, digit_idx_q));

  // Next-state and datapath; indicators decode from the next state.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    shadow_d     = shadow_q;
    digit_idx_d  = digit_idx_q;
    fail_count_d = fail_count_q;
    timer_d      = timer_q;

    case (state_q)
      S_LOCKED, S_ENTRY: begin
        if (enter_pulse) begin
          if (digit_match) begin
            if (digit_idx_q == LAST_IDX) begin
              state_d      = S_UNLOCKED;
              digit_idx_d  = 2'd0;
              fail_count_d = 2'd0;
            end else begin
              state_d     = S_ENTRY;
              digit_idx_d = digit_idx_q + 2'd1;
            end
          end else begin
            state_d     = S_ERROR;
            digit_idx_d = 2'd0;
            if (fail_count_q < FAIL_MAX) fail_count_d = fail_count_q + 2'd1;
          end
        end
      end
      S_ERROR: begin
        if (!enter_s2_q) begin
          if (fail_count_q == FAIL_MAX) begin
            state_d = S_LOCKOUT;
            timer_d = TIMER_INIT;
          end else begin
            state_d = S_LOCKED;
          end
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d      = S_LOCKED;
          fail_count_d = 2'd0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_UNLOCKED: begin
        if (relock) begin
          state_d = S_LOCKED;
        end else if (enter_pulse && prog_req) begin
          state_d     = S_PROGRAM;
          digit_idx_d = 2'd0;
          shadow_d    = '0;
        end
      end
      S_PROGRAM: begin
        if (relock) begin
          state_d     = S_LOCKED;
          digit_idx_d = 2'd0;
          shadow_d    = '0;
        end else if (enter_pulse) begin
          shadow_d = set_nib(shadow_q, digit_idx_q, digit_s2_q);
          if (digit_idx_q == LAST_IDX) begin
            // Only the active nibbles are committed; unused ones keep their value.
            for (int unsigned i = 0; i < 4; i++) begin
              if (i < CODE_LEN) code_d = set_nib(code_d, 2'(i), nib(shadow_d, 2'(i)));
            end
            state_d     = S_LOCKED;
            digit_idx_d = 2'd0;
          end else begin
            digit_idx_d = digit_idx_q + 2'd1;
          end
        end
      end
      default: state_d = S_LOCKED;
    endcase

    locked_d   = (state_d == S_LOCKED) || (state_d == S_ENTRY) ||
                 (state_d == S_ERROR)  || (state_d == S_LOCKOUT);
    unlocked_d = (state_d == S_UNLOCKED) || (state_d == S_PROGRAM);
    error_d    = (state_d == S_ERROR);
    lockout_d  = (state_d == S_LOCKOUT);
  end

  // Enter sync flops reset high so a key held through reset yields no pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_LOCKED;
      code_q       <= DEFAULT_CODE;
      shadow_q     <= '0;
      digit_idx_q  <= 2'd0;
      fail_count_q <= 2'd0;
      timer_q      <= '0;
      enter_s1_q   <= 1'b1;
      enter_s2_q   <= 1'b1;
      enter_prev_q <= 1'b1;
      digit_s1_q   <= 4'd0;
      digit_s2_q   <= 4'd0;
      locked_q     <= 1'b1;
      unlocked_q   <= 1'b0;
      error_q      <= 1'b0;
      lockout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      shadow_q     <= shadow_d;
      digit_idx_q  <= digit_idx_d;
      fail_count_q <= fail_count_d;
      timer_q      <= timer_d;
      enter_s1_q   <= enter_raw;
      enter_s2_q   <= enter_s1_q;
      enter_prev_q <= enter_s2_q;
      digit_s1_q   <= digit_raw;
      digit_s2_q   <= digit_s1_q;
      locked_q     <= locked_d;
      unlocked_q   <= unlocked_d;
      error_q      <= error_d;
      lockout_q    <= lockout_d;
    end
  end

  assign locked     = locked_q;
  assign unlocked   = unlocked_q;
  assign error      = error_q;
  assign lockout    = lockout_q;
  assign fail_count = fail_count_q;
  assign digit_idx  = digit_idx_q;
  assign state_code = state_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// Bench for lock_supervisor: directed scenarios plus random key presses checked
// against a press-level model of the lock.
module tb_lock_supervisor;

  localparam int unsigned LOCK_CYC = 16;
  localparam int M_LOCKED = 0;
  localparam int M_UNL    = 1;
  localparam int M_PROG   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter_raw;
  logic [3:0] digit_raw;
  logic       prog_req;
  logic       relock;
  logic       locked, unlocked, error, lockout;
  logic [1:0] fail_count, digit_idx;
  logic [2:0] state_code;
  logic [10:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  int m_code[4];
  int m_pbuf[4];
  int m_mode, m_pos, m_ppos, m_fails;

  always #5 clk = ~clk;

  lock_supervisor #(
    .CODE_LEN(4), .MAX_FAILS(3), .LOCKOUT_CYCLES(LOCK_CYC), .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk(clk), .reset(reset), .enter_raw(enter_raw), .digit_raw(digit_raw),
    .prog_req(prog_req), .relock(relock), .locked(locked), .unlocked(unlocked),
    .error(error), .lockout(lockout), .fail_count(fail_count), .digit_idx(digit_idx),
    .state_code(state_code)
  );

  assign obs = {locked, unlocked, error, lockout, fail_count, digit_idx, state_code};

  // Expected output vectors {locked,unlocked,error,lockout,fails,idx,state_code}
  function automatic logic [10:0] vec_settled();
    logic [10:0] v;
    case (m_mode)
      M_UNL:   v = {4'b0100, 2'(m_fails), 2'd0, 3'd3};
      M_PROG:  v = {4'b0100, 2'(m_fails), 2'(m_ppos), 3'd5};
      default: v = {4'b1000, 2'(m_fails), 2'(m_pos), (m_pos == 0) ? 3'd0 : 3'd1};
    endcase
    return v;
  endfunction

  function automatic logic [10:0] vec_error();
    return {4'b1010, 2'(m_fails), 2'd0, 3'd2};
  endfunction

  function automatic logic [10:0] vec_reset();
    return {4'b1000, 2'd0, 2'd0, 3'd0};
  endfunction

  task automatic model_reset();
    m_code = '{1, 2, 3, 4};
    m_mode = M_LOCKED; m_pos = 0; m_ppos = 0; m_fails = 0;
  endtask

  task automatic model_press(input int d, input bit prog, output bit wrong);
    wrong = 1'b0;
    case (m_mode)
      M_LOCKED: begin
        if (d == m_code[m_pos]) begin
          m_pos++;
          if (m_pos == 4) begin m_mode = M_UNL; m_pos = 0; m_fails = 0; end
        end else begin
          wrong = 1'b1; m_pos = 0;
          if (m_fails < 3) m_fails++;
        end
      end
      M_UNL: if (prog) begin m_mode = M_PROG; m_ppos = 0; end
      default: begin
        m_pbuf[m_ppos] = d;
        m_ppos++;
        if (m_ppos == 4) begin
          m_code = m_pbuf; m_mode = M_LOCKED; m_pos = 0; m_ppos = 0;
        end
      end
    endcase
  endtask

  task automatic model_relock();
    if (m_mode != M_LOCKED) begin m_mode = M_LOCKED; m_pos = 0; m_ppos = 0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    enter_raw = 1'b0; prog_req = 1'b0; relock = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs !== vec_reset()) begin
      n_bad++; $display("FAIL reset_values: got %b want %b", obs, vec_reset());
    end
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  // One complete key press: hold, check, release, check (and ride out any lockout).
  task automatic do_press(input int d, input bit prog);
    bit wrong;
    logic [10:0] exp;
    int cnt;
    bit ended;
    model_press(d, prog, wrong);
    @(negedge clk);
    digit_raw = 4'(d); prog_req = prog; enter_raw = 1'b1;
    repeat (6) @(negedge clk);
    exp = wrong ? vec_error() : vec_settled();
    n_cmp++;
    if (obs !== exp) begin
      n_bad++; $display("FAIL press_held d=%0d: got %b want %b", d, obs, exp);
    end
    enter_raw = 1'b0;
    if (wrong && m_fails == 3) begin
      cnt = 0; ended = 1'b0;
      digit_raw = 4'd1;
      for (int i = 0; i < 60 && !ended; i++) begin
        @(negedge clk);
        if (lockout) cnt++;
        else if (cnt > 0) ended = 1'b1;
        enter_raw = (i >= 3 && i < 11 && (i % 4) < 2);
      end
      n_cmp++;
      if (cnt != int'(LOCK_CYC) || !ended) begin
        n_bad++; $display("FAIL lockout_len: got %0d cycles (ended=%0d) want %0d", cnt, ended, LOCK_CYC);
      end
      m_fails = 0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    prog_req = 1'b0;
    n_cmp++;
    if (obs !== vec_settled()) begin
      n_bad++; $display("FAIL press_released d=%0d: got %b want %b", d, obs, vec_settled());
    end
  endtask

  task automatic do_relock();
    @(negedge clk);
    relock = 1'b1;
    repeat (2) @(negedge clk);
    relock = 1'b0;
    model_relock();
    @(negedge clk);
    n_cmp++;
    if (obs !== vec_settled()) begin
      n_bad++; $display("FAIL relock: got %b want %b", obs, vec_settled());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs !== vec_reset()) begin
      n_bad++; $display("FAIL after_reset: got %b want %b", obs, vec_reset());
    end
  endtask

  task automatic test_unlock();
    bit wrong;
    do_press(1, 0); do_press(2, 0); do_press(3, 0);
    model_press(4, 0, wrong);
    @(negedge clk);
    digit_raw = 4'd4; enter_raw = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (unlocked !== 1'b0) begin
      n_bad++; $display("FAIL unlock_early: got %b want 0", unlocked);
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== vec_settled()) begin
      n_bad++; $display("FAIL unlock_latency: got %b want %b", obs, vec_settled());
    end
    enter_raw = 1'b0;
    repeat (6) @(negedge clk);
    do_relock();
  endtask

  task automatic test_wrong_digit();
    do_press(1, 0);
    do_press(9, 0);
  endtask

  task automatic test_lockout();
    do_reset();
    for (int k = 0; k < 3; k++) do_press(int'($urandom_range(2, 15)), 0);
    do_press(1, 0);
  endtask

  task automatic test_program();
    do_reset();
    do_press(1, 0); do_press(2, 0); do_press(3, 0); do_press(4, 0);
    do_press(int'($urandom_range(0, 15)), 1);
    do_press(5, 0); do_press(6, 0); do_press(7, 0); do_press(8, 0);
    do_press(1, 0);
    do_press(5, 0); do_press(6, 0); do_press(7, 0); do_press(8, 0);
    do_relock();
  endtask

  task automatic test_prog_abort();
    do_reset();
    do_press(1, 0); do_press(2, 0); do_press(3, 0); do_press(4, 0);
    do_press(0, 1);
    do_press(5, 0); do_press(6, 0);
    // relock arrives in the same cycle as the pulse for digit 7
    @(negedge clk);
    digit_raw = 4'd7; enter_raw = 1'b1;
    repeat (2) @(negedge clk);
    relock = 1'b1;
    repeat (2) @(negedge clk);
    relock = 1'b0;
    model_relock();
    repeat (2) @(negedge clk);
    enter_raw = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (obs !== vec_settled()) begin
      n_bad++; $display("FAIL abort_relock: got %b want %b", obs, vec_settled());
    end
    do_press(1, 0); do_press(2, 0); do_press(3, 0); do_press(4, 0);
    do_relock();
  endtask

  task automatic test_enter_through_reset();
    @(negedge clk);
    digit_raw = 4'd1; enter_raw = 1'b1; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);
    n_cmp++;
    if (obs !== vec_settled()) begin
      n_bad++; $display("FAIL held_enter_reset: got %b want %b", obs, vec_settled());
    end
    enter_raw = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (obs !== vec_settled()) begin
      n_bad++; $display("FAIL held_enter_release: got %b want %b", obs, vec_settled());
    end
    do_press(1, 0);
  endtask

  task automatic test_reset_mid_entry();
    do_reset();
    do_press(1, 0); do_press(2, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== vec_reset()) begin
      n_bad++; $display("FAIL async_reset: got %b want %b", obs, vec_reset());
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    int r, d;
    bit prog;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      prog = 1'b0;
      if (r == 0 && m_mode != M_LOCKED) begin
        do_relock();
      end else begin
        case (m_mode)
          M_LOCKED: d = (r < 8) ? m_code[m_pos] : int'($urandom_range(0, 15));
          M_UNL: begin d = int'($urandom_range(0, 15)); prog = (r < 7); end
          default: d = int'($urandom_range(0, 15));
        endcase
        do_press(d, prog);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enter_raw = 1'b0; digit_raw = 4'd0; prog_req = 1'b0; relock = 1'b0;
    model_reset();
    test_reset();
    test_unlock();
    test_wrong_digit();
    test_lockout();
    test_program();
    test_prog_abort();
    test_enter_through_reset();
    test_reset_mid_entry();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
